instr_fetch_queue: RTL and testbench

Dual-slot instruction buffer between the fetch stage and the dual-issue decoder (U/V pipes). It accepts up to two `fetch_t` entries per cycle from fetch and presents the two oldest entries to decode in program order. Decode consumes 0, 1 or 2 of them per cycle. A flush from the branch-resolution path discards everything in flight.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/instr_fetch_queue.sv | 97 +++++++++
 tb/tb_instr_fetch_queue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the fetch -> queue -> decode boundary.
package pipeline_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        prd_taken;
   } fetch_t;

   typedef fetch_t [1:0] fetch_pair_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// Dual-slot circular instruction buffer feeding the U/V decoder in program order.
// Accepts up to two entries per cycle; decode pops 0-2 head entries per cycle.
module instr_fetch_queue
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_flush,
   input  fetch_pair_t   i_enq_data,
   output logic          o_enq_ready,
   output fetch_pair_t   o_deq_data,
   input  logic [1:0]    i_deq_cnt,
   output logic [CW-1:0] o_count,
   output logic          o_empty
);

   localparam int AW = $clog2(DEPTH);

   fetch_t        mem [DEPTH];
   logic [AW-1:0] rp;
   logic [AW-1:0] wp;
   logic [CW-1:0] cnt;
   logic [1:0]    enq_n;
   logic [1:0]    pop;
   logic          wr_en;

   // A request of 3 means 2; never pop more than is actually held.
   function automatic logic [1:0] clamp_pop(input logic [1:0] req, input logic [CW-1:0] occ);
      logic [1:0] r;
      r = (req == 2'd3) ? 2'd2 : req;
      if (occ < CW'(r)) r = occ[1:0];
      return r;
   endfunction

   assign o_enq_ready = (cnt <= CW'(DEPTH - 2));
   assign o_count     = cnt;
   assign o_empty     = (cnt == '0);

   assign wr_en = o_enq_ready && !i_flush && i_rst_n;
   assign enq_n = o_enq_ready ? (2'(i_enq_data[0].valid) + 2'(i_enq_data[1].valid)) : 2'd0;
   assign pop   = clamp_pop(i_deq_cnt, cnt);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
      end else begin
         rp  <= rp + AW'(pop);
         wp  <= wp + AW'(enq_n);
         cnt <= cnt + CW'(enq_n) - CW'(pop);
      end
   end

   // Slot-1-only bundles are compacted into wp so the buffer never holds bubbles.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         if (i_enq_data[0].valid && i_enq_data[1].valid) begin
            mem[wp]          <= i_enq_data[0];
            mem[wp + AW'(1)] <= i_enq_data[1];
         end else if (i_enq_data[0].valid) begin
            mem[wp] <= i_enq_data[0];
         end else if (i_enq_data[1].valid) begin
            mem[wp] <= i_enq_data[1];
         end
      end
   end

   always_comb begin
      o_deq_data = '0;
      if (cnt >= CW'(1)) begin
         o_deq_data[0]       = mem[rp];
         o_deq_data[0].valid = 1'b1;
      end
      if (cnt >= CW'(2)) begin
         o_deq_data[1]       = mem[rp + AW'(1)];
         o_deq_data[1].valid = 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (i_rst_n && !i_flush) begin
         assert (cnt <= CW'(DEPTH))
            else $error("occupancy %0d above depth", cnt);
         assert (!(wr_en && (enq_n != 2'd0) && !o_enq_ready))
            else $error("write while not ready");
         assert (((i_deq_cnt == 2'd3) ? 2'd2 : i_deq_cnt) <= cnt)
            else $warning("decode requested %0d entries with only %0d held", i_deq_cnt, cnt);
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=8).
module tb_instr_fetch_queue;
   import pipeline_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        flush;
   fetch_pair_t enq_data;
   logic        enq_ready;
   fetch_pair_t deq_data;
   logic [1:0]  deq_cnt;
   logic [3:0]  count;
   logic        empty;

   int tests = 0;
   int fails = 0;
   logic [31:0] sb[$];

   instr_fetch_queue #(.DEPTH(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_flush     (flush),
      .i_enq_data  (enq_data),
      .o_enq_ready (enq_ready),
      .o_deq_data  (deq_data),
      .i_deq_cnt   (deq_cnt),
      .o_count     (count),
      .o_empty     (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic fetch_t mk(input logic [31:0] pc);
      fetch_t f;
      f.valid     = 1'b1;
      f.pc        = pc;
      f.instr     = pc ^ 32'hA5A5_0000;
      f.prd_taken = pc[2];
      return f;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle;
      enq_data = '0;
      deq_cnt  = 2'd0;
      flush    = 1'b0;
   endtask

   task automatic set_pair(input logic [31:0] pc0, input logic [31:0] pc1);
      enq_data[0] = mk(pc0);
      enq_data[1] = mk(pc1);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      set_idle();
      set_pair(32'hDEAD_0000, 32'hDEAD_0004);
      step();
      tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %0b want 1", empty); end
      tests++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", enq_ready); end
      tests++; if (deq_data !== '0) begin fails++; $display("FAIL reset_deq got %h want 0", deq_data); end
      rst_n = 1'b1;
      set_idle();
   endtask

   task automatic test_single_slot;
      set_pair(32'h0, 32'h4);
      #1;
      tests++; if (empty !== 1'b1 || deq_data[0].valid !== 1'b0) begin
         fails++; $display("FAIL no_bypass empty=%0b v0=%0b want 1,0", empty, deq_data[0].valid); end
      step();
      set_idle();
      tests++; if (count !== 4'd2) begin fails++; $display("FAIL pair_count got %0d want 2", count); end
      tests++; if (deq_data[0].pc !== 32'h0 || deq_data[1].pc !== 32'h4) begin
         fails++; $display("FAIL pair_pc got %h,%h want 0,4", deq_data[0].pc, deq_data[1].pc); end
      tests++; if (deq_data[0].valid !== 1'b1 || deq_data[1].valid !== 1'b1) begin
         fails++; $display("FAIL pair_valid got %0b,%0b want 1,1", deq_data[0].valid, deq_data[1].valid); end
      tests++; if (deq_data[1].instr !== 32'hA5A5_0004 || deq_data[1].prd_taken !== 1'b1) begin
         fails++; $display("FAIL pair_fields got %h,%0b want a5a50004,1", deq_data[1].instr, deq_data[1].prd_taken); end
      enq_data[1] = mk(32'h8);
      deq_cnt     = 2'd1;
      step();
      set_idle();
      tests++; if (count !== 4'd2) begin fails++; $display("FAIL slot1_count got %0d want 2", count); end
      tests++; if (deq_data[0].pc !== 32'h4 || deq_data[1].pc !== 32'h8) begin
         fails++; $display("FAIL slot1_pc got %h,%h want 4,8", deq_data[0].pc, deq_data[1].pc); end
      deq_cnt = 2'd2;
      step();
      set_idle();
      tests++; if (count !== 4'd0 || empty !== 1'b1 || deq_data !== '0) begin
         fails++; $display("FAIL drain got count=%0d empty=%0b want 0,1", count, empty); end
   endtask

   task automatic test_fill;
      for (int i = 0; i < 4; i++) begin
         tests++; if (enq_ready !== 1'b1) begin fails++; $display("FAIL fill_ready_%0d got 0 want 1", i); end
         set_pair(32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i));
         step();
      end
      set_idle();
      tests++; if (count !== 4'd8 || enq_ready !== 1'b0) begin
         fails++; $display("FAIL full got count=%0d ready=%0b want 8,0", count, enq_ready); end
      set_pair(32'h200, 32'h204);
      step();
      set_idle();
      tests++; if (count !== 4'd8 || deq_data[0].pc !== 32'h100) begin
         fails++; $display("FAIL full_ignore got count=%0d head=%h want 8,100", count, deq_data[0].pc); end
      deq_cnt = 2'd1;
      step();
      set_idle();
      tests++; if (count !== 4'd7 || enq_ready !== 1'b0) begin
         fails++; $display("FAIL depth_m1 got count=%0d ready=%0b want 7,0", count, enq_ready); end
      set_pair(32'h208, 32'h20C);
      deq_cnt = 2'd2;
      step();
      set_idle();
      tests++; if (count !== 4'd5 || enq_ready !== 1'b1 || deq_data[0].pc !== 32'h10C) begin
         fails++; $display("FAIL pop_at_m1 got count=%0d ready=%0b head=%h want 5,1,10c", count, enq_ready, deq_data[0].pc); end
   endtask

   task automatic test_flush;
      flush = 1'b1;
      set_pair(32'h280, 32'h284);
      deq_cnt = 2'd2;
      step();
      set_idle();
      tests++; if (count !== 4'd0 || empty !== 1'b1 || enq_ready !== 1'b1) begin
         fails++; $display("FAIL flush_state got count=%0d empty=%0b ready=%0b want 0,1,1", count, empty, enq_ready); end
      tests++; if (deq_data !== '0) begin fails++; $display("FAIL flush_deq got %h want 0", deq_data); end
      set_pair(32'h300, 32'h304);
      step();
      set_idle();
      tests++; if (count !== 4'd2 || deq_data[0].pc !== 32'h300 || deq_data[1].pc !== 32'h304) begin
         fails++; $display("FAIL post_flush got count=%0d pc=%h,%h want 2,300,304", count, deq_data[0].pc, deq_data[1].pc); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] next_pc;
      sb = {32'h300, 32'h304};
      next_pc = 32'h308;
      for (int i = 0; i < 2; i++) begin
         set_pair(next_pc, next_pc + 32'd4);
         sb.push_back(next_pc);
         sb.push_back(next_pc + 32'd4);
         next_pc += 32'd8;
         step();
      end
      set_idle();
      tests++; if (count !== 4'd6) begin fails++; $display("FAIL b2b_start got %0d want 6", count); end
      for (int i = 0; i < 16; i++) begin
         tests++; if (deq_data[0].pc !== sb[0] || deq_data[1].pc !== sb[1]) begin
            fails++; $display("FAIL b2b_order_%0d got %h,%h want %h,%h", i, deq_data[0].pc, deq_data[1].pc, sb[0], sb[1]); end
         set_pair(next_pc, next_pc + 32'd4);
         sb.push_back(next_pc);
         sb.push_back(next_pc + 32'd4);
         next_pc += 32'd8;
         void'(sb.pop_front());
         void'(sb.pop_front());
         deq_cnt = 2'd2;
         step();
         set_idle();
         tests++; if (count !== 4'd6 || enq_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_count_%0d got count=%0d ready=%0b want 6,1", i, count, enq_ready); end
      end
      for (int i = 0; i < 3; i++) begin
         tests++; if (deq_data[0].pc !== sb[0] || deq_data[1].pc !== sb[1]) begin
            fails++; $display("FAIL drain_order_%0d got %h,%h want %h,%h", i, deq_data[0].pc, deq_data[1].pc, sb[0], sb[1]); end
         void'(sb.pop_front());
         void'(sb.pop_front());
         deq_cnt = 2'd3;
         step();
         set_idle();
         tests++; if (count !== 4'(4 - 2 * i)) begin
            fails++; $display("FAIL drain_count_%0d got %0d want %0d", i, count, 4 - 2 * i); end
      end
   endtask

   task automatic test_overpop_and_reset;
      enq_data[0] = mk(32'h400);
      step();
      set_idle();
      tests++; if (count !== 4'd1 || deq_data[0].pc !== 32'h400 || deq_data[1].valid !== 1'b0) begin
         fails++; $display("FAIL one_entry got count=%0d head=%h v1=%0b want 1,400,0", count, deq_data[0].pc, deq_data[1].valid); end
      deq_cnt = 2'd2;
      step();
      set_idle();
      tests++; if (count !== 4'd0 || empty !== 1'b1) begin
         fails++; $display("FAIL overpop got count=%0d empty=%0b want 0,1", count, empty); end
      for (int i = 0; i < 3; i++) begin
         set_pair(32'h500 + 32'(8 * i), 32'h504 + 32'(8 * i));
         step();
      end
      set_idle();
      tests++; if (count !== 4'd6) begin fails++; $display("FAIL pre_reset got %0d want 6", count); end
      rst_n = 1'b0;
      set_pair(32'h600, 32'h604);
      deq_cnt = 2'd1;
      step();
      rst_n = 1'b1;
      set_idle();
      tests++; if (count !== 4'd0 || empty !== 1'b1 || enq_ready !== 1'b1 || deq_data !== '0) begin
         fails++; $display("FAIL mid_reset got count=%0d empty=%0b ready=%0b want 0,1,1", count, empty, enq_ready); end
   endtask

   initial begin
      rst_n = 1'b0;
      set_idle();
      test_reset();
      test_single_slot();
      test_fill();
      test_flush();
      test_back_to_back();
      test_overpop_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
